// File: rtl/div_su_pipe_pkg.sv
// ============================================================================
// Module : div_su_pipe_pkg
// Brief  : Shared types and helpers for the signed/unsigned pipelined divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package div_su_pipe_pkg;

  typedef struct packed {
    logic div0;
    logic ovf;
    logic neg_q;
    logic neg_r;
  } div_flags_t;

  function automatic div_flags_t make_flags(
    input logic is_signed,
    input logic sign_a,
    input logic sign_b,
    input logic dvs_zero,
    input logic dvd_min,
    input logic dvs_all_ones
  );
    div_flags_t f;
    f.div0  = dvs_zero;
    f.ovf   = is_signed & dvd_min & dvs_all_ones;
    f.neg_q = is_signed & (sign_a ^ sign_b);
    f.neg_r = is_signed & sign_a;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_su_pipe_stage.sv
// ============================================================================
// Module : div_stage
// Brief  : Combinational restoring-division step, BITS_PER_STAGE bits at once.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_stage #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_STAGE = 1
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;

  // i_quo holds the unconsumed dividend bits in its MSBs and the quotient bits
  // accumulated so far in its LSBs.
  always_comb begin
    w_rem  = i_rem;
    w_quo  = i_quo;
    w_sh   = '0;
    w_diff = '0;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      w_sh   = {w_rem, w_quo[WIDTH-1]};
      w_diff = w_sh - {1'b0, i_divisor};
      if (w_diff[WIDTH]) begin
        w_rem = w_sh[WIDTH-1:0];
        w_quo = {w_quo[WIDTH-2:0], 1'b0};
      end else begin
        w_rem = w_diff[WIDTH-1:0];
        w_quo = {w_quo[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign o_rem = w_rem;
  assign o_quo = w_quo;

endmodule

`default_nettype wire

// File: rtl/div_su_pipe.sv
// ============================================================================
// Module : div_su_pipe
// Brief  : Fully pipelined signed/unsigned divider with valid/tag sideband.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_su_pipe
  import div_su_pipe_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div0,
  output logic             o_overflow,
  output logic [TAG_W-1:0] o_tag
);

  localparam int             c_N_STAGES = WIDTH / BITS_PER_STAGE;
  localparam int             c_LATENCY  = c_N_STAGES + 2;
  localparam logic [WIDTH-1:0] c_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 4) begin : g_chk_width
    $error("div_su_pipe: WIDTH must be at least 4");
  end
  if (!(BITS_PER_STAGE == 1 || BITS_PER_STAGE == 2 || BITS_PER_STAGE == 4) ||
      (WIDTH % BITS_PER_STAGE) != 0) begin : g_chk_bps
    $error("div_su_pipe: BITS_PER_STAGE must be 1, 2 or 4 and divide WIDTH");
  end

  // Stage 0 operand conditioning
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  div_flags_t       w_flags;

  assign w_sign_a = i_signed & i_dividend[WIDTH-1];
  assign w_sign_b = i_signed & i_divisor[WIDTH-1];
  assign w_a_mag  = w_sign_a ? -i_dividend : i_dividend;
  assign w_b_mag  = w_sign_b ? -i_divisor  : i_divisor;
  assign w_flags  = make_flags(i_signed, w_sign_a, w_sign_b, (i_divisor == '0),
                               (i_dividend == c_MIN), (i_divisor == '1));

  // Pipeline storage: index 0 is the input register, index s is after stage s
  logic [c_LATENCY-2:0] r_valid;
  logic [WIDTH-1:0]     r_rem   [0:c_N_STAGES];
  logic [WIDTH-1:0]     r_quo   [0:c_N_STAGES];
  logic [WIDTH-1:0]     r_dvs   [0:c_N_STAGES-1];
  logic [WIDTH-1:0]     r_dvd   [0:c_N_STAGES];
  div_flags_t           r_flags [0:c_N_STAGES];
  logic [TAG_W-1:0]     r_tag   [0:c_N_STAGES];

  logic [WIDTH-1:0] w_rem_nxt [0:c_N_STAGES-1];
  logic [WIDTH-1:0] w_quo_nxt [0:c_N_STAGES-1];

  for (genvar s = 0; s < c_N_STAGES; s++) begin : g_stage
    div_stage #(
      .WIDTH          (WIDTH),
      .BITS_PER_STAGE (BITS_PER_STAGE)
    ) u_stage (
      .i_rem     (r_rem[s]),
      .i_quo     (r_quo[s]),
      .i_divisor (r_dvs[s]),
      .o_rem     (w_rem_nxt[s]),
      .o_quo     (w_quo_nxt[s])
    );
  end

  // Output-stage sign correction and special cases
  div_flags_t       w_fl_last;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign w_fl_last = r_flags[c_N_STAGES];

  always_comb begin
    w_q_fin = w_fl_last.neg_q ? -r_quo[c_N_STAGES] : r_quo[c_N_STAGES];
    w_r_fin = w_fl_last.neg_r ? -r_rem[c_N_STAGES] : r_rem[c_N_STAGES];
    if (w_fl_last.div0) begin
      w_q_fin = '1;
      w_r_fin = r_dvd[c_N_STAGES];
    end else if (w_fl_last.ovf) begin
      w_q_fin = c_MIN;
      w_r_fin = '0;
    end
  end

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_quo;
  logic [WIDTH-1:0] r_out_rem;
  logic             r_out_div0;
  logic             r_out_ovf;
  logic [TAG_W-1:0] r_out_tag;

  // Only validity is reset; the data path is gated by it at the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= '0;
      r_out_valid <= 1'b0;
    end else if (i_enable) begin
      r_valid     <= {r_valid[c_LATENCY-3:0], i_valid};
      r_out_valid <= r_valid[c_LATENCY-2];
    end
  end

  always_ff @(posedge clk) begin
    if (i_enable) begin
      r_rem[0]   <= '0;
      r_quo[0]   <= w_a_mag;
      r_dvs[0]   <= w_b_mag;
      r_dvd[0]   <= i_dividend;
      r_flags[0] <= w_flags;
      r_tag[0]   <= i_tag;
      for (int s = 0; s < c_N_STAGES; s++) begin
        r_rem[s+1]   <= w_rem_nxt[s];
        r_quo[s+1]   <= w_quo_nxt[s];
        r_dvd[s+1]   <= r_dvd[s];
        r_flags[s+1] <= r_flags[s];
        r_tag[s+1]   <= r_tag[s];
      end
      for (int s = 0; s < c_N_STAGES - 1; s++) begin
        r_dvs[s+1] <= r_dvs[s];
      end
      r_out_quo  <= w_q_fin;
      r_out_rem  <= w_r_fin;
      r_out_div0 <= w_fl_last.div0;
      r_out_ovf  <= w_fl_last.ovf & ~w_fl_last.div0;
      r_out_tag  <= r_tag[c_N_STAGES];
    end
  end

  assign o_valid     = r_out_valid;
  assign o_quotient  = r_out_valid ? r_out_quo : '0;
  assign o_remainder = r_out_valid ? r_out_rem : '0;
  assign o_div0      = r_out_valid & r_out_div0;
  assign o_overflow  = r_out_valid & r_out_ovf;
  assign o_tag       = r_out_valid ? r_out_tag : '0;

endmodule

`default_nettype wire

// File: tb/tb_div_su_pipe.sv
// ============================================================================
// Module : tb_div_su_pipe
// Brief  : Directed-vector and model-checked bench for div_su_pipe variants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_div_su_pipe;

  typedef struct packed {
    logic        v;
    logic [31:0] q;
    logic [31:0] r;
    logic        d0;
    logic        ov;
    logic [3:0]  tag;
  } res_t;

  typedef struct {
    logic        v;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [3:0]  tag;
  } in_t;

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [15:0] q;
    logic [15:0] r;
    logic        d0;
    logic        ov;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        en;
  logic        vld;
  logic        sgn;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [3:0]  tag;

  logic        v0, v1, v2, v3;
  logic [15:0] q0, q1, q2, r0, r1, r2;
  logic [31:0] q3, r3;
  logic        z0, z1, z2, z3, o0, o1, o2, o3;
  logic [3:0]  t0, t1, t2, t3;

  div_su_pipe #(.WIDTH(16), .BITS_PER_STAGE(1), .TAG_W(4)) u_d0 (
    .clk(clk), .reset_n(reset_n), .i_enable(en), .i_valid(vld), .i_signed(sgn),
    .i_dividend(a16), .i_divisor(b16), .i_tag(tag),
    .o_valid(v0), .o_quotient(q0), .o_remainder(r0), .o_div0(z0), .o_overflow(o0), .o_tag(t0));
  div_su_pipe #(.WIDTH(16), .BITS_PER_STAGE(2), .TAG_W(4)) u_d1 (
    .clk(clk), .reset_n(reset_n), .i_enable(en), .i_valid(vld), .i_signed(sgn),
    .i_dividend(a16), .i_divisor(b16), .i_tag(tag),
    .o_valid(v1), .o_quotient(q1), .o_remainder(r1), .o_div0(z1), .o_overflow(o1), .o_tag(t1));
  div_su_pipe #(.WIDTH(16), .BITS_PER_STAGE(4), .TAG_W(4)) u_d2 (
    .clk(clk), .reset_n(reset_n), .i_enable(en), .i_valid(vld), .i_signed(sgn),
    .i_dividend(a16), .i_divisor(b16), .i_tag(tag),
    .o_valid(v2), .o_quotient(q2), .o_remainder(r2), .o_div0(z2), .o_overflow(o2), .o_tag(t2));
  div_su_pipe #(.WIDTH(32), .BITS_PER_STAGE(4), .TAG_W(4)) u_d3 (
    .clk(clk), .reset_n(reset_n), .i_enable(en), .i_valid(vld), .i_signed(sgn),
    .i_dividend(a32), .i_divisor(b32), .i_tag(tag),
    .o_valid(v3), .o_quotient(q3), .o_remainder(r3), .o_div0(z3), .o_overflow(o3), .o_tag(t3));

  int lat [4] = '{18, 10, 6, 10};
  int wid [4] = '{16, 16, 16, 32};

  in_t hist [0:4095];
  int  en_cnt;
  int  n_tests;
  int  n_fail;

  function automatic res_t act(input int d);
    res_t x;
    case (d)
      0:       x = '{v0, {16'd0, q0}, {16'd0, r0}, z0, o0, t0};
      1:       x = '{v1, {16'd0, q1}, {16'd0, r1}, z1, o1, t1};
      2:       x = '{v2, {16'd0, q2}, {16'd0, r2}, z2, o2, t2};
      default: x = '{v3, q3, r3, z3, o3, t3};
    endcase
    return x;
  endfunction

  // Arithmetic reference using the simulator's own integer division.
  function automatic res_t ref_div(input int w, input logic s, input longint unsigned a,
                                   input longint unsigned b, input logic [3:0] t);
    res_t            x;
    longint unsigned mask;
    longint unsigned minv;
    longint          sa, sb, qq, rr;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    x = '0;
    x.v = 1'b1;
    x.tag = t;
    if (b == 0) begin
      x.q  = 32'(mask);
      x.r  = 32'(a);
      x.d0 = 1'b1;
    end else if (s && a == minv && b == mask) begin
      x.q  = 32'(minv);
      x.ov = 1'b1;
    end else if (s) begin
      sa = ((a >> (w - 1)) & 1) != 0 ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb = ((b >> (w - 1)) & 1) != 0 ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      qq = sa / sb;
      rr = sa % sb;
      x.q = 32'(longint'(qq) & longint'(mask));
      x.r = 32'(longint'(rr) & longint'(mask));
    end else begin
      x.q = 32'(a / b);
      x.r = 32'(a % b);
    end
    return x;
  endfunction

  function automatic res_t expect_of(input int d);
    int  idx;
    in_t x;
    idx = en_cnt - lat[d];
    if (idx < 0) return '0;
    x = hist[idx];
    if (!x.v) return '0;
    if (d == 3) return ref_div(32, x.sgn, 64'(x.a32), 64'(x.b32), x.tag);
    return ref_div(16, x.sgn, 64'(x.a), 64'(x.b), x.tag);
  endfunction

  task automatic check(input string name, input int d, input res_t got, input res_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got v=%b q=%h r=%h d0=%b ov=%b tag=%h, expected v=%b q=%h r=%h d0=%b ov=%b tag=%h",
               name, d, got.v, got.q, got.r, got.d0, got.ov, got.tag,
               exp.v, exp.q, exp.r, exp.d0, exp.ov, exp.tag);
    end
  endtask

  task automatic step(input in_t x, input logic e);
    en  = e;
    vld = x.v;
    sgn = x.sgn;
    a16 = x.a;
    b16 = x.b;
    a32 = x.a32;
    b32 = x.b32;
    tag = x.tag;
    @(posedge clk);
    if (e) begin
      hist[en_cnt] = x;
      en_cnt++;
    end
    #1;
    for (int d = 0; d < 4; d++) check("model", d, act(d), expect_of(d));
  endtask

  function automatic in_t mk(input logic v, input logic s, input logic [15:0] a,
                             input logic [15:0] b, input logic [3:0] t);
    in_t x;
    x.v = v; x.sgn = s; x.a = a; x.b = b; x.tag = t;
    x.a32 = s ? {{16{a[15]}}, a} : {16'd0, a};
    x.b32 = s ? {{16{b[15]}}, b} : {16'd0, b};
    return x;
  endfunction

  function automatic in_t rnd(input logic v, input logic [3:0] t);
    in_t x;
    x.v = v; x.tag = t;
    x.sgn = 1'($urandom_range(0, 1));
    x.a = 16'($urandom); x.b = 16'($urandom);
    x.a32 = $urandom; x.b32 = $urandom;
    case ($urandom_range(0, 7))
      0: begin x.b = 16'd0; x.b32 = 32'd0; end
      1: begin x.a = 16'h8000; x.b = 16'hFFFF; x.a32 = 32'h8000_0000; x.b32 = 32'hFFFF_FFFF; end
      2: begin x.b = 16'($urandom_range(1, 15)); x.b32 = 32'($urandom_range(1, 15)); end
      3: begin x.b = 16'hFFFF; x.b32 = 32'hFFFF_FFFE; end
      default: ;
    endcase
    return x;
  endfunction

  vec_t vecs [12];
  in_t  bub;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    en_cnt  = 0;
    vecs[0]  = '{1'b0, 16'd100,   16'd7,    4'h5, 16'd14,   16'd2,    1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'hFFF9,  16'h0002, 4'h1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0007,  16'hFFFE, 4'h2, 16'hFFFD, 16'h0001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'd1234,  16'h0000, 4'h3, 16'hFFFF, 16'd1234, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 16'h8000,  16'hFFFF, 4'h4, 16'h8000, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 16'h8000,  16'hFFFF, 4'h6, 16'h0000, 16'h8000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'hFFFF,  16'h0001, 4'h7, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h8000,  16'h0002, 4'h8, 16'hC000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0000,  16'h0000, 4'h9, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'hFFF9,  16'hFFFE, 4'hA, 16'h0003, 16'hFFFF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h0005,  16'h0009, 4'hB, 16'h0000, 16'h0005, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'h8001,  16'h7FFF, 4'hC, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    bub = mk(1'b0, 1'b0, 16'd0, 16'd0, 4'h0);

    reset_n = 1'b0;
    en = 1'b0; vld = 1'b0; sgn = 1'b0;
    a16 = '0; b16 = '0; a32 = '0; b32 = '0; tag = '0;
    #22;
    for (int d = 0; d < 4; d++) check("reset_state", d, act(d), '0);
    reset_n = 1'b1;

    // Directed vectors, one at a time, exact latency per variant
    for (int i = 0; i < 12; i++) begin
      res_t hexp;
      hexp = '{1'b1, {16'd0, vecs[i].q}, {16'd0, vecs[i].r}, vecs[i].d0, vecs[i].ov, vecs[i].tag};
      step(mk(1'b1, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag), 1'b1);
      for (int s = 2; s <= 18; s++) begin
        step(bub, 1'b1);
        for (int d = 0; d < 3; d++) begin
          if (s == lat[d]) check($sformatf("vec%0d", i), d, act(d), hexp);
          if (s == lat[d] - 1) check($sformatf("vec%0d_early", i), d, act(d), '0);
        end
      end
    end

    // Tagged stream with bubbles and a three-cycle stall
    for (int t = 0; t < 10; t++) begin
      if (t == 5) for (int k = 0; k < 3; k++) step(rnd(1'b1, 4'hF), 1'b0);
      if (t % 3 == 2) step(bub, 1'b1);
      step(rnd(1'b1, 4'(t)), 1'b1);
    end
    for (int k = 0; k < 20; k++) step(bub, 1'b1);

    // Random mixed traffic with random enable and valid
    for (int k = 0; k < 300; k++)
      step(rnd(($urandom_range(0, 3) != 0), 4'($urandom)), ($urandom_range(0, 9) != 0));
    for (int k = 0; k < 20; k++) step(bub, 1'b1);

    // Asynchronous reset with a full pipe
    for (int k = 0; k < 20; k++) step(rnd(1'b1, 4'(k)), 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) check("async_reset", d, act(d), '0);
    en_cnt = 0;
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) step(bub, 1'b1);
    step(mk(1'b1, 1'b0, 16'd100, 16'd7, 4'h5), 1'b1);
    for (int k = 0; k < 20; k++) step(bub, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
